mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_if.sv | 40 ++++
 rtl/mem_wb_stage.sv | 110 +++++++++++
 tb/tb_mem_wb_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if -- EX-side inputs and WB/branch-side outputs of the MEM/WB stage.
//   master : the EX stage / environment side (drives ex_*, flush; observes results)
//   slave  : the mem_wb_stage block
//   ex_*       : EX/MEM capture inputs (valid, ALU result, store data, dest reg, controls)
//   flush      : squash the instruction captured from EX this edge
//   wb_*       : register-file write-back port
//   pc_src/pc_target : taken-branch redirect, one-cycle pulse
//   mem_valid/wb_valid : pipeline register occupancy for monitoring
interface mem_wb_stage_if;
   logic        ex_valid;
   logic [15:0] ex_alu_out;
   logic [15:0] ex_rd2;
   logic [1:0]  ex_wr;
   logic        ex_regwrite;
   logic        ex_memtoreg;
   logic        ex_memwrite;
   logic [1:0]  ex_branch;
   logic        ex_zero;
   logic [15:0] ex_target;
   logic        flush;
   logic [15:0] wb_wd;
   logic [1:0]  wb_wr;
   logic        wb_regwrite;
   logic        pc_src;
   logic [15:0] pc_target;
   logic        mem_valid;
   logic        wb_valid;

   modport master (
      output ex_valid, ex_alu_out, ex_rd2, ex_wr, ex_regwrite, ex_memtoreg,
             ex_memwrite, ex_branch, ex_zero, ex_target, flush,
      input  wb_wd, wb_wr, wb_regwrite, pc_src, pc_target, mem_valid, wb_valid
   );

   modport slave (
      input  ex_valid, ex_alu_out, ex_rd2, ex_wr, ex_regwrite, ex_memtoreg,
             ex_memwrite, ex_branch, ex_zero, ex_target, flush,
      output wb_wd, wb_wr, wb_regwrite, pc_src, pc_target, mem_valid, wb_valid
   );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- EX/MEM register, 256x16 data memory and MEM/WB register of a
// small 16-bit CPU. All state advances on the falling edge of clk.
//   clk   : pipeline clock (falling-edge active)
//   rst_n : synchronous active-low reset, clears both pipeline registers only
//   bus   : mem_wb_stage_if.slave, EX inputs in, write-back / branch outputs out
module mem_wb_stage (
   input  logic             clk,
   input  logic             rst_n,
   mem_wb_stage_if.slave    bus
);

   typedef struct packed {
      logic        valid;
      logic [15:0] alu_out;
      logic [15:0] rd2;
      logic [1:0]  wr;
      logic        regwrite;
      logic        memtoreg;
      logic        memwrite;
      logic [1:0]  branch;
      logic        zero;
      logic [15:0] target;
   } ex_mem_t;

   typedef struct packed {
      logic        valid;
      logic [15:0] wd;
      logic [1:0]  wr;
      logic        regwrite;
   } mem_wb_t;

   ex_mem_t     ex_mem_d, ex_mem_q;
   mem_wb_t     mem_wb_d, mem_wb_q;

   // Contents survive reset; the initialiser only gives simulation a known start.
   logic [15:0] dmem_q [0:255] = '{default: '0};

   logic [7:0]  mem_idx;
   logic [15:0] mem_rdata;
   logic        is_branch;
   logic        mem_we;
   logic        taken;

   // ---------------- EX/MEM capture ----------------
   always_comb begin
      ex_mem_d          = '0;
      ex_mem_d.valid    = bus.ex_valid & ~bus.flush;
      ex_mem_d.alu_out  = bus.ex_alu_out;
      ex_mem_d.rd2      = bus.ex_rd2;
      ex_mem_d.wr       = bus.ex_wr;
      ex_mem_d.regwrite = bus.ex_regwrite;
      ex_mem_d.memtoreg = bus.ex_memtoreg;
      ex_mem_d.memwrite = bus.ex_memwrite;
      ex_mem_d.branch   = bus.ex_branch;
      ex_mem_d.zero     = bus.ex_zero;
      ex_mem_d.target   = bus.ex_target;
   end

   // ---------------- MEM stage ----------------
   always_comb begin
      // Halfword-aligned word index; upper bits wrap modulo 256 words.
      mem_idx   = ex_mem_q.alu_out[8:1];
      mem_rdata = dmem_q[mem_idx];
      // Branches are never allowed to touch memory or registers, even with
      // stray control bits set.
      is_branch = |ex_mem_q.branch;
      mem_we    = ex_mem_q.valid & ex_mem_q.memwrite & ~is_branch;
      taken     = ex_mem_q.valid &
                  ((ex_mem_q.branch[0] & ex_mem_q.zero) |
                   (ex_mem_q.branch[1] & ~ex_mem_q.zero));
   end

   always_comb begin
      mem_wb_d          = '0;
      mem_wb_d.valid    = ex_mem_q.valid;
      mem_wb_d.wd       = ex_mem_q.memtoreg ? mem_rdata : ex_mem_q.alu_out;
      mem_wb_d.wr       = ex_mem_q.wr;
      mem_wb_d.regwrite = ex_mem_q.valid & ex_mem_q.regwrite & ~ex_mem_q.memwrite &
                          ~is_branch & (ex_mem_q.wr != 2'd0);
   end

   // ---------------- state ----------------
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   // A store pending at a reset edge is dropped.
   always_ff @(negedge clk) begin
      if (rst_n && mem_we)
         dmem_q[mem_idx] <= ex_mem_q.rd2;
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.wb_wd       = mem_wb_q.wd;
      bus.wb_wr       = mem_wb_q.wr;
      bus.wb_regwrite = mem_wb_q.regwrite;
      bus.wb_valid    = mem_wb_q.valid;
      bus.mem_valid   = ex_mem_q.valid;
      bus.pc_src      = taken;
      bus.pc_target   = ex_mem_q.target;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage -- directed-vector bench for mem_wb_stage. Inputs change and
// outputs are sampled on the rising edge, half a cycle away from the active
// falling edge.
module tb_mem_wb_stage;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance through one falling edge and land on the next rising edge.
   task automatic step();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] rd2,
                        input logic [1:0] wr, input logic rw, input logic m2r,
                        input logic mw, input logic [1:0] br, input logic z,
                        input logic [15:0] tgt, input logic fl);
      bus.ex_valid    = v;
      bus.ex_alu_out  = alu;
      bus.ex_rd2      = rd2;
      bus.ex_wr       = wr;
      bus.ex_regwrite = rw;
      bus.ex_memtoreg = m2r;
      bus.ex_memwrite = mw;
      bus.ex_branch   = br;
      bus.ex_zero     = z;
      bus.ex_target   = tgt;
      bus.flush       = fl;
   endtask

   task automatic bubble();
      drive(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_valid"},   32'(bus.mem_valid),   32'd0);
      chk({tag, ".wb_valid"},    32'(bus.wb_valid),    32'd0);
      chk({tag, ".wb_regwrite"}, 32'(bus.wb_regwrite), 32'd0);
      chk({tag, ".wb_wd"},       32'(bus.wb_wd),       32'd0);
      chk({tag, ".wb_wr"},       32'(bus.wb_wr),       32'd0);
      chk({tag, ".pc_src"},      32'(bus.pc_src),      32'd0);
      chk({tag, ".pc_target"},   32'(bus.pc_target),   32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bubble();
      @(posedge clk);
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // ADDI: alu=15 -> $1
      drive(1'b1, 16'd15, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      chk("addi.mem_valid", 32'(bus.mem_valid), 32'd1);
      chk("addi.pc_src",    32'(bus.pc_src),    32'd0);
      bubble();
      step();
      chk("addi.wb_wd",       32'(bus.wb_wd),       32'd15);
      chk("addi.wb_wr",       32'(bus.wb_wr),       32'd1);
      chk("addi.wb_regwrite", 32'(bus.wb_regwrite), 32'd1);
      chk("addi.wb_valid",    32'(bus.wb_valid),    32'd1);

      // SW 0x00AB -> 0x0006 (regwrite deliberately set: must be suppressed),
      // then LW 0x0006 -> $2 back to back.
      drive(1'b1, 16'h0006, 16'h00AB, 2'd3, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      drive(1'b1, 16'h0006, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      chk("sw.wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
      chk("sw.wb_valid",    32'(bus.wb_valid),    32'd1);
      bubble();
      step();
      chk("lw.wb_wd",       32'(bus.wb_wd),       32'h00AB);
      chk("lw.wb_wr",       32'(bus.wb_wr),       32'd2);
      chk("lw.wb_regwrite", 32'(bus.wb_regwrite), 32'd1);

      // Address wrap: SW to 0x0206 lands on word 3; read back via 0x0006 and 0x0007.
      drive(1'b1, 16'h0206, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      drive(1'b1, 16'h0006, 16'h0, 2'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      drive(1'b1, 16'h0007, 16'h0, 2'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      chk("wrap.wb_wd", 32'(bus.wb_wd), 32'h1234);
      chk("wrap.wb_wr", 32'(bus.wb_wr), 32'd1);
      bubble();
      step();
      chk("odd.wb_wd", 32'(bus.wb_wd), 32'h1234);
      chk("odd.wb_wr", 32'(bus.wb_wr), 32'd3);

      // BEQ taken: one-cycle pulse, no register write.
      drive(1'b1, 16'h0, 16'h0, 2'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 16'h0010, 1'b0);
      step();
      chk("beq.pc_src",    32'(bus.pc_src),    32'd1);
      chk("beq.pc_target", 32'(bus.pc_target), 32'h0010);
      bubble();
      step();
      chk("beq.pulse_end",   32'(bus.pc_src),      32'd0);
      chk("beq.wb_regwrite", 32'(bus.wb_regwrite), 32'd0);

      // BNE with zero=1: not taken.
      drive(1'b1, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 16'h0020, 1'b0);
      step();
      chk("bne_nt.pc_src", 32'(bus.pc_src), 32'd0);
      // BNE with zero=0: taken.
      drive(1'b1, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'h0024, 1'b0);
      step();
      chk("bne_t.pc_src",    32'(bus.pc_src),    32'd1);
      chk("bne_t.pc_target", 32'(bus.pc_target), 32'h0024);

      // Bubble carrying taken-branch / store / regwrite controls: all inert.
      drive(1'b0, 16'h0006, 16'h5555, 2'd1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 16'h0030, 1'b0);
      step();
      chk("bubble.pc_src",    32'(bus.pc_src),    32'd0);
      chk("bubble.mem_valid", 32'(bus.mem_valid), 32'd0);
      bubble();
      step();
      chk("bubble.wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
      chk("bubble.wb_valid",    32'(bus.wb_valid),    32'd0);

      // Write to $0 is dropped.
      drive(1'b1, 16'd5, 16'h0, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      bubble();
      step();
      chk("r0.wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
      chk("r0.wb_valid",    32'(bus.wb_valid),    32'd1);

      // Flushed SW must not store; word 3 still holds 0x1234.
      drive(1'b1, 16'h0006, 16'hDEAD, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 1'b1);
      step();
      chk("flush.mem_valid", 32'(bus.mem_valid), 32'd0);
      drive(1'b1, 16'h0006, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      bubble();
      step();
      chk("flush.mem_word", 32'(bus.wb_wd), 32'h1234);

      // Reset while a SW sits in EX/MEM and an ADDI sits in MEM/WB.
      drive(1'b1, 16'd7, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      drive(1'b1, 16'h0006, 16'hBEEF, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0040, 1'b0);
      step();
      chk("prerst.mem_valid",   32'(bus.mem_valid),   32'd1);
      chk("prerst.wb_regwrite", 32'(bus.wb_regwrite), 32'd1);
      rst_n = 1'b0;
      bubble();
      step();
      chk_all_zero("midrst");
      rst_n = 1'b1;
      drive(1'b1, 16'h0006, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 1'b0);
      step();
      bubble();
      step();
      chk("midrst.mem_word", 32'(bus.wb_wd),       32'h1234);
      chk("midrst.resume",   32'(bus.wb_regwrite), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
